// File: rtl/debounce_bank.sv
// debounce_bank: N-channel push-button/switch debouncer.
// Per channel: 2-flop synchroniser, stability counter, debounced level,
// rise/fall pulses and long-press detection.
// Optional auto-repeat while a key stays held: define DEBOUNCE_BANK_REPEAT_EN.
// Without it rpt_o is tied to 0 and no repeat logic exists.

module debounce_lane #(
  parameter int STABLE_CYCLES = 131072,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic out_o,
  output logic onup_o,
  output logic ondn_o,
  output logic long_press_o,
  output logic rpt_o
);
  localparam int CW   = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = (HMAX > 2) ? $clog2(HMAX) : 1;

  logic          pin;
  logic          sync0_q, sync1_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          onup_q, onup_d, ondn_q, ondn_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          held_q, held_d;
  logic          lp_q, lp_d;
`ifdef DEBOUNCE_BANK_REPEAT_EN
  logic          rpt_q, rpt_d;
`endif

  // Fold pin polarity in before the synchroniser so everything downstream is active-high.
  assign pin = in_i ^ (ACTIVE_LOW != 0);

  // Stability counter: out follows sync1 only after it has differed for STABLE_CYCLES edges.
  always_comb begin
    cnt_d  = '0;
    out_d  = out_q;
    onup_d = 1'b0;
    ondn_d = 1'b0;
    if (sync1_q != out_q) begin
      if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
        out_d  = sync1_q;
        onup_d = sync1_q;
        ondn_d = ~sync1_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Hold timer. A falling out_d suppresses any pulse landing in the ondn cycle.
  always_comb begin
    hold_d = hold_q;
    held_d = held_q;
    lp_d   = 1'b0;
`ifdef DEBOUNCE_BANK_REPEAT_EN
    rpt_d  = 1'b0;
`endif
    if (!out_q || !out_d) begin
      hold_d = '0;
      held_d = 1'b0;
    end else if (!held_q) begin
      if (hold_q == HW'(HOLD_CYCLES - 1)) begin
        lp_d   = 1'b1;
        hold_d = '0;
        held_d = 1'b1;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
`ifdef DEBOUNCE_BANK_REPEAT_EN
    else begin
      if (hold_q == HW'(REPEAT_CYCLES - 1)) begin
        rpt_d  = 1'b1;
        hold_d = '0;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
`endif
  end

  // All channel state; asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      onup_q  <= 1'b0;
      ondn_q  <= 1'b0;
      hold_q  <= '0;
      held_q  <= 1'b0;
      lp_q    <= 1'b0;
    end else begin
      sync0_q <= pin;
      sync1_q <= sync0_q;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      onup_q  <= onup_d;
      ondn_q  <= ondn_d;
      hold_q  <= hold_d;
      held_q  <= held_d;
      lp_q    <= lp_d;
    end
  end

`ifdef DEBOUNCE_BANK_REPEAT_EN
  // Repeat pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rpt_q <= 1'b0;
    else        rpt_q <= rpt_d;
  end
  assign rpt_o = rpt_q;
`else
  assign rpt_o = 1'b0;
`endif

  assign out_o        = out_q;
  assign onup_o       = onup_q;
  assign ondn_o       = ondn_q;
  assign long_press_o = lp_q;
endmodule

module debounce_bank #(
  parameter int N             = 4,
  parameter int STABLE_CYCLES = 131072,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_i,
  output logic [N-1:0] out_o,
  output logic [N-1:0] onup_o,
  output logic [N-1:0] ondn_o,
  output logic [N-1:0] long_press_o,
  output logic [N-1:0] rpt_o,
  output logic         any_active_o
);
  logic any_active_q;

  debounce_lane #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) u_lane [N-1:0] (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_i        (in_i),
    .out_o       (out_o),
    .onup_o      (onup_o),
    .ondn_o      (ondn_o),
    .long_press_o(long_press_o),
    .rpt_o       (rpt_o)
  );

  // Registered OR of all levels; lags out_o by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_active_q <= 1'b0;
    else        any_active_q <= |out_o;
  end

  assign any_active_o = any_active_q;
endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: two instances (active-high and active-low pins).
// Expected pulses are queued as (edge, kind, channel) codes when stimulus is
// driven; a negedge monitor pops one per observed pulse and compares.
module tb_debounce_bank;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] in_a, in_b;
  logic [N-1:0] out_a, onup_a, ondn_a, lp_a, rpt_a;
  logic [N-1:0] out_b, onup_b, ondn_b, lp_b, rpt_b;
  logic         any_a, any_b;

  int edge_n = 0;
  int pass_n = 0;
  int fail_n = 0;
  int total_n = 0;
  int sb[$];

  logic [3:0][7:0] pv;

  debounce_bank #(.N(N), .STABLE_CYCLES(4), .HOLD_CYCLES(16), .REPEAT_CYCLES(8), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_i(in_a), .out_o(out_a), .onup_o(onup_a), .ondn_o(ondn_a),
    .long_press_o(lp_a), .rpt_o(rpt_a), .any_active_o(any_a));

  debounce_bank #(.N(N), .STABLE_CYCLES(4), .HOLD_CYCLES(16), .REPEAT_CYCLES(8), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_i(in_b), .out_o(out_b), .onup_o(onup_b), .ondn_o(ondn_b),
    .long_press_o(lp_b), .rpt_o(rpt_b), .any_active_o(any_b));

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int got, input int exp);
    total_n++;
    assert (got === exp) pass_n++;
    else begin
      fail_n++;
      $error("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // kind: 0 onup, 1 ondn, 2 long_press, 3 rpt; ch 4..7 are dut_b lanes
  function automatic void push(input int cyc, input int kind, input int ch);
    sb.push_back(cyc * 100 + kind * 10 + ch);
  endfunction

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Pulse monitor against the scoreboard.
  always @(negedge clk) begin
    pv[0] = {onup_b, onup_a};
    pv[1] = {ondn_b, ondn_a};
    pv[2] = {lp_b, lp_a};
    pv[3] = {rpt_b, rpt_a};
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 8; c++)
        if (pv[k][c]) begin
          if (sb.size() == 0) chk("spurious_pulse", edge_n * 100 + k * 10 + c, -1);
          else chk("pulse", edge_n * 100 + k * 10 + c, sb.pop_front());
        end
  end

  initial begin
    int t;
    in_a = '0;
    in_b = '1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_a", 32'({out_a, onup_a, ondn_a, lp_a, rpt_a, any_a}), 0);
    chk("reset_b", 32'({out_b, onup_b, ondn_b, lp_b, rpt_b, any_b}), 0);
    go(3);
    rst_n = 1'b1;
    go(4);

    // 1: clean rise on ch0, 6-edge latency, then release
    t = edge_n;
    in_a[0] = 1'b1;
    push(t + 6, 0, 0);
    go(5);
    chk("s1_out_before", 32'(out_a[0]), 0);
    go(1);
    chk("s1_out_after", 32'(out_a[0]), 1);
    go(2);
    in_a[0] = 1'b0;
    push(t + 14, 1, 0);
    go(12);

    // 2: 3-cycle glitch rejected, then bounce settling to one onup
    in_a[1] = 1'b1;
    go(3);
    in_a[1] = 1'b0;
    go(4);
    chk("s2_glitch_out", 32'(out_a[1]), 0);
    go(4);
    in_a[1] = 1'b1; go(1);
    in_a[1] = 1'b0; go(1);
    in_a[1] = 1'b1; go(1);
    in_a[1] = 1'b0; go(1);
    in_a[1] = 1'b1;
    t = edge_n;
    push(t + 6, 0, 1);
    go(8);
    in_a[1] = 1'b0;
    push(t + 14, 1, 1);
    go(12);

    // 3: long press on ch2 (and repeats when compiled in)
    t = edge_n;
    in_a[2] = 1'b1;
    push(t + 6, 0, 2);
    push(t + 22, 2, 2);
`ifdef DEBOUNCE_BANK_REPEAT_EN
    push(t + 30, 3, 2);
    push(t + 38, 3, 2);
`endif
    push(t + 42, 1, 2);
    go(36);
    in_a[2] = 1'b0;
    go(20);

    // 4: release ch3 before hold expires; ondn lands where long_press would
    t = edge_n;
    in_a[3] = 1'b1;
    push(t + 6, 0, 3);
    go(16);
    in_a[3] = 1'b0;
    push(t + 22, 1, 3);
    go(20);

    // 5: simultaneous rise on ch0/ch3; any_active lags by one
    t = edge_n;
    in_a[0] = 1'b1;
    in_a[3] = 1'b1;
    push(t + 6, 0, 0);
    push(t + 6, 0, 3);
    go(6);
    chk("s5_any_lag", 32'(any_a), 0);
    go(1);
    chk("s5_any_high", 32'(any_a), 1);
    go(1);
    in_a[0] = 1'b0;
    in_a[3] = 1'b0;
    push(t + 14, 1, 0);
    push(t + 14, 1, 3);
    go(7);
    chk("s5_any_low", 32'(any_a), 0);
    go(10);

    // 6: async reset mid-press (ch2) and mid-count (ch1)
    t = edge_n;
    in_a[2] = 1'b1;
    push(t + 6, 0, 2);
    go(10);
    in_a[1] = 1'b1;
    go(3);
    chk("s6_pre_rst", 32'(out_a), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_a", 32'({out_a, onup_a, ondn_a, lp_a, rpt_a, any_a}), 0);
    go(3);
    rst_n = 1'b1;
    t = edge_n;
    push(t + 6, 0, 1);
    push(t + 6, 0, 2);
    go(5);
    chk("s6_out_before", 32'(out_a), 0);
    go(1);
    chk("s6_out_after", 32'(out_a), 6);
    go(2);
    in_a[1] = 1'b0;
    in_a[2] = 1'b0;
    push(t + 14, 1, 1);
    push(t + 14, 1, 2);
    go(12);

    // 7: active-low instance, idle at all-ones, press ch0 by driving 0
    chk("s7_idle", 32'({out_b, any_b}), 0);
    t = edge_n;
    in_b[0] = 1'b0;
    push(t + 6, 0, 4);
    go(6);
    chk("s7_out", 32'(out_b), 1);
    go(2);
    in_b[0] = 1'b1;
    push(t + 14, 1, 4);
    go(20);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
